// File: rtl/mem_txn_if.sv
// mem_txn_if: host request port and SPI controller command/response signals.
// master = scheduler side, slave = host/controller side.
interface mem_txn_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              spi_start;
    logic [1:0]        spi_cmd;
    logic [ADDR_W-1:0] spi_addr;
    logic [8:0]        spi_len;
    logic              spi_busy;
    logic              spi_done;
    logic [7:0]        spi_status;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  spi_busy, spi_done, spi_status,
        output req_ready, spi_start, spi_cmd, spi_addr, spi_len
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output spi_busy, spi_done, spi_status,
        input  req_ready, spi_start, spi_cmd, spi_addr, spi_len
    );
endinterface

// File: rtl/mem_txn_scheduler.sv
// mem_txn_scheduler: splits one host read/program request into page-bounded
// SPI flash commands, issuing WREN before and WIP status polling after each
// program chunk. Build macro MEM_SCHED_ABORT_EN adds the abort/aborted ports.
module mem_txn_scheduler #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned CHUNK_BYTES = 256,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned POLL_MAX    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    mem_txn_if.master   bus,
    output logic [15:0] txn_completed,
    output logic [15:0] txn_total,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef MEM_SCHED_ABORT_EN
    ,
    input  logic        abort,
    output logic        aborted
`endif
);
    localparam int unsigned CB_LOG2 = $clog2(CHUNK_BYTES);
    localparam int unsigned SUM_W   = LEN_W + 2;
    localparam int unsigned PC_W    = $clog2(POLL_MAX + 1);
    localparam int unsigned GC_W    = $clog2(POLL_GAP + 1);

    localparam logic [1:0] CMD_READ = 2'b00;
    localparam logic [1:0] CMD_PP   = 2'b01;
    localparam logic [1:0] CMD_RDSR = 2'b10;
    localparam logic [1:0] CMD_WREN = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_WAIT_WREN, S_ISSUE, S_WAIT,
        S_GAP, S_POLL, S_POLL_WAIT, S_FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              write_op;
    logic [PC_W-1:0]   poll_cnt;
    logic [GC_W-1:0]   gap_cnt;

    logic [8:0]        room_c;
    logic [8:0]        chunk_c;
    logic [LEN_W-1:0]  rem_next_c;
    logic [SUM_W-1:0]  total_sum_c;
    logic              resp_c;
    logic              stop_c;
    logic              unused_status;

    // Chunk sizing: stop at the next page boundary or the end of the request.
    assign room_c      = 9'(CHUNK_BYTES) - 9'(addr & ADDR_W'(CHUNK_BYTES - 1));
    assign chunk_c     = (remaining < LEN_W'(room_c)) ? 9'(remaining) : room_c;
    assign rem_next_c  = remaining - LEN_W'(chunk_c);
    assign total_sum_c = SUM_W'(bus.req_addr & ADDR_W'(CHUNK_BYTES - 1))
                       + SUM_W'(bus.req_len) + SUM_W'(CHUNK_BYTES - 1);

    // A completion in the launch cycle cannot belong to the new command.
    assign resp_c        = bus.spi_done && !bus.spi_start;
    assign unused_status = ^bus.spi_status[7:1];

`ifdef MEM_SCHED_ABORT_EN
    logic abort_pend;
    assign stop_c = abort_pend || abort;
`else
    assign stop_c = 1'b0;
`endif

    // Request sequencing FSM with registered SPI command and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            write_op      <= 1'b0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
            bus.req_ready <= 1'b1;
            bus.spi_start <= 1'b0;
            bus.spi_cmd   <= CMD_READ;
            bus.spi_addr  <= '0;
            bus.spi_len   <= '0;
            txn_completed <= '0;
            txn_total     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
`ifdef MEM_SCHED_ABORT_EN
            abort_pend    <= 1'b0;
            aborted       <= 1'b0;
`endif
        end else begin
            bus.spi_start <= 1'b0;
            done          <= 1'b0;
`ifdef MEM_SCHED_ABORT_EN
            if (state != S_IDLE && abort) abort_pend <= 1'b1;
`endif
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr          <= bus.req_addr;
                        remaining     <= bus.req_len;
                        write_op      <= bus.req_write;
                        poll_cnt      <= '0;
                        txn_completed <= '0;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
`ifdef MEM_SCHED_ABORT_EN
                        abort_pend    <= 1'b0;
                        aborted       <= 1'b0;
`endif
                        if (bus.req_len == '0) begin
                            txn_total <= '0;
                            err       <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_FINISH;
                        end else begin
                            txn_total <= 16'(total_sum_c >> CB_LOG2);
                            err       <= 1'b0;
                            state     <= bus.req_write ? S_WREN : S_ISSUE;
                        end
                    end
                end
                S_WREN: begin
                    if (!bus.spi_busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_cmd   <= CMD_WREN;
                        bus.spi_addr  <= addr;
                        bus.spi_len   <= '0;
                        state         <= S_WAIT_WREN;
                    end
                end
                S_WAIT_WREN: begin
                    if (resp_c) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!bus.spi_busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_cmd   <= write_op ? CMD_PP : CMD_READ;
                        bus.spi_addr  <= addr;
                        bus.spi_len   <= chunk_c;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_c) begin
                        txn_completed <= txn_completed + 16'd1;
                        addr          <= addr + ADDR_W'(chunk_c);
                        remaining     <= rem_next_c;
                        if (write_op) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else if (rem_next_c != '0 && !stop_c) begin
                            state <= S_ISSUE;
                        end else begin
`ifdef MEM_SCHED_ABORT_EN
                            if (stop_c && rem_next_c != '0) aborted <= 1'b1;
`endif
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GC_W'(POLL_GAP - 1)) state <= S_POLL;
                    else gap_cnt <= gap_cnt + GC_W'(1);
                end
                S_POLL: begin
                    if (!bus.spi_busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_cmd   <= CMD_RDSR;
                        bus.spi_len   <= '0;
                        poll_cnt      <= poll_cnt + PC_W'(1);
                        state         <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (resp_c) begin
                        if (bus.spi_status[0]) begin
                            if (poll_cnt == PC_W'(POLL_MAX)) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end else begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                        end else begin
                            poll_cnt <= '0;
                            if (remaining != '0 && !stop_c) begin
                                state <= S_WREN;
                            end else begin
`ifdef MEM_SCHED_ABORT_EN
                                if (stop_c && remaining != '0) aborted <= 1'b1;
`endif
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    bus.req_ready <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
